// File: rtl/clk_enable_bank.sv
// Bank of runtime-programmable clock-enable channels: per-channel strobe, square and busy,
// with a valid/ready period/mode load that takes effect only at a period boundary.

module clk_enable_lane #(
    parameter int WIDTH        = 16,
    parameter int RESET_PERIOD = 50
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           resync,
    input  logic           accept,
    input  logic [WIDTH:0] load_bits,
    output logic           pending,
    output logic           strobe,
    output logic           square,
    output logic           busy
);
    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic             oneshot;
    } load_t;

    load_t            ld, shadow;
    logic [WIDTH-1:0] cnt, period, period_m1, p_nx, cnt_nx, high_len;
    logic             oneshot, os_nx, expired, exp_nx;
    logic             halted, wrap, xfer, stb_nx, sq_run, busy_nx;

    assign ld        = load_t'(load_bits);
    assign period_m1 = period - WIDTH'(1);
    assign halted    = ~en | (period == '0);
    // period_m1 only matters when period != 0, so no underflow reaches the compare
    assign wrap      = ~resync & ~halted & ~expired & (cnt == period_m1);
    assign xfer      = pending & (resync | halted | expired | wrap);
    assign p_nx      = xfer ? shadow.period  : period;
    assign os_nx     = xfer ? shadow.oneshot : oneshot;
    assign high_len  = p_nx - (p_nx >> 1);

    always_comb begin
        cnt_nx = '0;
        exp_nx = expired;
        stb_nx = 1'b0;
        sq_run = 1'b0;
        if (resync) begin
            exp_nx = 1'b0;
            sq_run = 1'b1;
        end else if (halted) begin
            exp_nx = 1'b0;
        end else if (expired) begin
            exp_nx = ~xfer;
        end else if (wrap) begin
            stb_nx = 1'b1;
            exp_nx = oneshot & ~xfer;
            sq_run = 1'b1;
        end else begin
            cnt_nx = cnt + WIDTH'(1);
            sq_run = 1'b1;
        end
        busy_nx = en & (p_nx != '0) & ~exp_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            period  <= WIDTH'(RESET_PERIOD);
            oneshot <= 1'b0;
            expired <= 1'b0;
            shadow  <= '0;
            pending <= 1'b0;
            strobe  <= 1'b0;
            square  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            period  <= p_nx;
            oneshot <= os_nx;
            expired <= exp_nx;
            pending <= (pending & ~xfer) | accept;
            if (accept) shadow <= ld;
            strobe  <= stb_nx;
            square  <= sq_run & busy_nx & (cnt_nx < high_len);
            busy    <= busy_nx;
        end
    end
endmodule

module clk_enable_bank #(
    parameter int  CHANNELS     = 4,
    parameter int  WIDTH        = 16,
    parameter int  RESET_PERIOD = 50,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                resync,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    load_period,
    input  logic                load_oneshot,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] square,
    output logic [CHANNELS-1:0] busy
);
    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic             oneshot;
    } load_t;

    load_t               load_req;
    logic [CHANNELS-1:0] pending;

    assign load_req = '{period: load_period, oneshot: load_oneshot};

    // Out-of-range channel numbers are always ready and land nowhere
    always_comb begin
        load_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++)
            if (load_ch == CH_W'(i)) load_ready = ~pending[i];
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        clk_enable_lane #(
            .WIDTH        (WIDTH),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (ch_en[i]),
            .resync    (resync),
            .accept    (load_valid & load_ready & (load_ch == CH_W'(i))),
            .load_bits (load_req),
            .pending   (pending[i]),
            .strobe    (strobe[i]),
            .square    (square[i]),
            .busy      (busy[i])
        );
    end
endmodule

// File: tb/tb_clk_enable_bank.sv
// Scenario bench for clk_enable_bank: expected strobe edges are queued up front and
// matched against observed strobes, plus inline level checks.

module tb_clk_enable_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic        resync, load_valid, load_ready, load_oneshot;
    logic [1:0]  load_ch;
    logic [15:0] load_period;
    logic [3:0]  strobe, square, busy;

    logic [2:0]  ch_en3, strobe3, square3, busy3;
    logic        load_valid3, load_ready3;
    logic [1:0]  load_ch3;
    logic [7:0]  load_period3;

    int checks = 0;
    int errors = 0;
    int q[$];
    int q3[$];

    always #5 clk = ~clk;

    clk_enable_bank #(.CHANNELS(4), .WIDTH(16), .RESET_PERIOD(50)) u_dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .resync(resync),
        .load_valid(load_valid), .load_ready(load_ready), .load_ch(load_ch),
        .load_period(load_period), .load_oneshot(load_oneshot),
        .strobe(strobe), .square(square), .busy(busy)
    );

    clk_enable_bank #(.CHANNELS(3), .WIDTH(8), .RESET_PERIOD(5)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en3), .resync(1'b0),
        .load_valid(load_valid3), .load_ready(load_ready3), .load_ch(load_ch3),
        .load_period(load_period3), .load_oneshot(1'b0),
        .strobe(strobe3), .square(square3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = '0; resync = 1'b0; load_valid = 1'b0; load_ch = '0;
        load_period = '0; load_oneshot = 1'b0;
        ch_en3 = '0; load_valid3 = 1'b0; load_ch3 = '0; load_period3 = '0;
        tick(); tick();
        checks++; if (strobe !== 4'b0) begin errors++; $display("FAIL reset_strobe got %b want 0000", strobe); end
        checks++; if (square !== 4'b0) begin errors++; $display("FAIL reset_square got %b want 0000", square); end
        checks++; if (busy !== 4'b0) begin errors++; $display("FAIL reset_busy got %b want 0000", busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", load_ready); end
    endtask

    task automatic test_periodic();
        int hi = 0;
        int exp_e;
        logic other = 1'b0;
        rst_n = 1'b1; ch_en = 4'b0001;
        q = '{50, 100, 150};
        for (int e = 1; e <= 150; e++) begin
            tick();
            if (e <= 50 && square[0]) hi++;
            if (strobe[3:1] !== 3'b0) other = 1'b1;
            if (e == 1) begin checks++; if (square[0] !== 1'b1) begin errors++; $display("FAIL per_sq_e1 got %b want 1", square[0]); end end
            if (e == 25) begin checks++; if (square[0] !== 1'b0) begin errors++; $display("FAIL per_sq_e25 got %b want 0", square[0]); end end
            if (e == 10) begin checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL per_busy got %b want 1", busy[0]); end end
            if (strobe[0]) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL per_strobe extra at edge %0d want none", e); end
                else begin exp_e = q.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL per_strobe at edge %0d want %0d", e, exp_e); end end
            end
        end
        checks++; if (hi !== 25) begin errors++; $display("FAIL per_square_high got %0d want 25", hi); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL per_missing got %0d left want 0", q.size()); end
        checks++; if (other !== 1'b0) begin errors++; $display("FAIL per_other_strobe got 1 want 0"); end
    endtask

    task automatic test_reload();
        int exp_e;
        ch_en = 4'b0000;
        load_valid = 1'b1; load_ch = 2'd1; load_period = 16'd10; load_oneshot = 1'b0;
        tick();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rl_pending_ready got %b want 0", load_ready); end
        tick();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rl_idle_xfer_ready got %b want 1", load_ready); end
        ch_en = 4'b0010;
        q = '{10, 13, 16, 19};
        for (int e = 1; e <= 20; e++) begin
            if (e == 5) begin load_period = 16'd3; load_valid = 1'b1; end
            tick();
            load_valid = 1'b0;
            if (e == 9) begin checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rl_ready_e9 got %b want 0", load_ready); end end
            if (e == 10) begin checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rl_ready_e10 got %b want 1", load_ready); end end
            if (strobe[1]) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rl_strobe extra at edge %0d want none", e); end
                else begin exp_e = q.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL rl_strobe at edge %0d want %0d", e, exp_e); end end
            end
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rl_missing got %0d left want 0", q.size()); end
    endtask

    task automatic test_oneshot();
        int exp_e;
        ch_en = 4'b0000;
        load_valid = 1'b1; load_ch = 2'd2; load_period = 16'd4; load_oneshot = 1'b1;
        tick();
        load_valid = 1'b0; load_oneshot = 1'b0;
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            ch_en = 4'b0100;
            q = '{4};
            for (int e = 1; e <= 10; e++) begin
                tick();
                if (e == 3) begin checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL os_busy_e3 got %b want 1", busy[2]); end end
                if (e == 6) begin checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL os_busy_e6 got %b want 0", busy[2]); end end
                if (strobe[2]) begin
                    checks++;
                    if (q.size() == 0) begin errors++; $display("FAIL os_strobe extra at edge %0d want none", e); end
                    else begin exp_e = q.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL os_strobe at edge %0d want %0d", e, exp_e); end end
                end
            end
            checks++; if (q.size() !== 0) begin errors++; $display("FAIL os_missing pass %0d got %0d left want 0", pass, q.size()); end
            ch_en = 4'b0000;
            tick();
        end
    endtask

    task automatic test_resync();
        int exp_e;
        ch_en = 4'b0000;
        load_valid = 1'b1; load_ch = 2'd0; load_period = 16'd1;
        tick();
        load_ch = 2'd3; load_period = 16'd2;
        tick();
        load_valid = 1'b0;
        tick();
        ch_en = 4'b1001;
        q = '{2, 4, 6, 9, 11};
        for (int e = 1; e <= 12; e++) begin
            if (e == 7) resync = 1'b1;
            tick();
            resync = 1'b0;
            checks++;
            if (strobe[0] !== (e != 7)) begin errors++; $display("FAIL rs_p1_strobe edge %0d got %b want %b", e, strobe[0], e != 7); end
            if (strobe[3]) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rs_strobe3 extra at edge %0d want none", e); end
                else begin exp_e = q.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL rs_strobe3 at edge %0d want %0d", e, exp_e); end end
            end
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rs_missing got %0d left want 0", q.size()); end
        checks++; if (square[0] !== 1'b1) begin errors++; $display("FAIL rs_p1_square got %b want 1", square[0]); end
        ch_en = 4'b0000;
        tick();
    endtask

    task automatic test_halt_and_range();
        int exp_e;
        ch_en = 4'b0010; ch_en3 = 3'b001;
        q = '{3, 6};
        q3 = '{5, 10};
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) begin load_valid = 1'b1; load_ch = 2'd1; load_period = 16'd0; end
            if (e == 2) begin
                load_valid3 = 1'b1; load_ch3 = 2'd3; load_period3 = 8'd2;
                checks++; if (load_ready3 !== 1'b1) begin errors++; $display("FAIL range_ready got %b want 1", load_ready3); end
            end
            tick();
            load_valid = 1'b0; load_valid3 = 1'b0;
            if (e == 8) begin
                checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL halt_busy got %b want 0", busy[1]); end
                checks++; if (square[1] !== 1'b0) begin errors++; $display("FAIL halt_square got %b want 0", square[1]); end
                checks++; if (busy3[0] !== 1'b1) begin errors++; $display("FAIL range_busy got %b want 1", busy3[0]); end
            end
            if (strobe[1]) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL halt_strobe extra at edge %0d want none", e); end
                else begin exp_e = q.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL halt_strobe at edge %0d want %0d", e, exp_e); end end
            end
            if (strobe3[0]) begin
                checks++;
                if (q3.size() == 0) begin errors++; $display("FAIL range_strobe extra at edge %0d want none", e); end
                else begin exp_e = q3.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL range_strobe at edge %0d want %0d", e, exp_e); end end
            end
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL halt_missing got %0d left want 0", q.size()); end
        checks++; if (q3.size() !== 0) begin errors++; $display("FAIL range_missing got %0d left want 0", q3.size()); end
        ch_en = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midflight();
        int exp_e;
        ch_en = 4'b0100;
        for (int e = 1; e <= 3; e++) begin
            if (e == 3) begin load_valid = 1'b1; load_ch = 2'd2; load_period = 16'd9; load_oneshot = 1'b0; end
            tick();
            load_valid = 1'b0;
            checks++; if (strobe[2] !== 1'b0) begin errors++; $display("FAIL mid_early_strobe edge %0d got 1 want 0", e); end
        end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_pending_ready got %b want 0", load_ready); end
        rst_n = 1'b0;
        tick();
        checks++; if ({strobe, square, busy} !== 12'b0) begin errors++; $display("FAIL mid_reset_outs got %b want 0", {strobe, square, busy}); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", load_ready); end
        rst_n = 1'b1;
        q = '{50};
        for (int e = 1; e <= 55; e++) begin
            tick();
            if (e == 1) begin checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy[2]); end end
            if (strobe[2]) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL mid_strobe extra at edge %0d want none", e); end
                else begin exp_e = q.pop_front(); if (e !== exp_e) begin errors++; $display("FAIL mid_strobe at edge %0d want %0d", e, exp_e); end end
            end
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL mid_missing got %0d left want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_reload();
        test_oneshot();
        test_resync();
        test_halt_and_range();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1);
    end
endmodule
